// File: rtl/fusion_pe_acc.sv
// Bit-fusion PE: packed 2/4/8-bit lane dot product, accumulated over a
// programmable number of beats onto a bias, result returned over a handshake.
//
// state  | meaning
// IDLE   | waiting for a configuration strobe
// ACCUM  | accepting beats and draining the two-stage product pipeline
// DRAIN  | result held on out_data until the downstream handshake
module fusion_pe_acc #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [3:0]        cfg_in_width,
    input  logic [3:0]        cfg_weight_width,
    input  logic              cfg_s_in,
    input  logic              cfg_s_weight,
    input  logic [CNT_W-1:0]  cfg_acc_len,
    input  logic [ACC_W-1:0]  cfg_psum_init,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] weight_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy
);

    localparam int LANES = DATA_W / 2;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    state_t              r_state, w_next;
    logic [3:0]          r_iw, r_ww;
    logic                r_s_in, r_s_w;
    logic [CNT_W-1:0]    r_acc_len, r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic                r_v1, r_v2;
    logic [DATA_W-1:0]   r_in1, r_w1;
    logic [ACC_W-1:0]    r_sum2;

    logic                w_in_ready, w_accept;
    logic [3:0]          w_lw;
    logic signed [8:0]   w_a [LANES];
    logic signed [8:0]   w_b [LANES];
    logic signed [17:0]  w_p [LANES];
    logic [ACC_W-1:0]    w_sum;

    function automatic logic [3:0] norm_w(input logic [3:0] c);
        case (c)
            4'd2:    return 4'd2;
            4'd4:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic signed [8:0] ext_op(input logic [7:0] v, input logic [3:0] wd,
                                                 input logic s);
        case (wd)
            4'd2:    return {{7{s & v[1]}}, v[1:0]};
            4'd4:    return {{5{s & v[3]}}, v[3:0]};
            default: return {s & v[7], v[7:0]};
        endcase
    endfunction

    // Lane slots use W = max(iw, ww), but each operand is picked at its own width
    always_comb begin
        w_sum = '0;
        w_lw  = (r_iw > r_ww) ? r_iw : r_ww;
        for (int k = 0; k < LANES; k++) begin
            w_a[k] = '0;
            w_b[k] = '0;
            if ((k + 1) * int'(w_lw) <= DATA_W) begin
                w_a[k] = ext_op(8'(r_in1 >> (k * int'(r_iw))), r_iw, r_s_in);
                w_b[k] = ext_op(8'(r_w1 >> (k * int'(r_ww))), r_ww, r_s_w);
            end
            w_p[k] = w_a[k] * w_b[k];
            w_sum  = w_sum + {{(ACC_W-18){w_p[k][17]}}, w_p[k]};
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid)
                    w_next = (cfg_acc_len == '0) ? S_DRAIN : S_ACCUM;
            end
            S_ACCUM: begin
                w_in_ready = (r_cnt < r_acc_len);
                // Last beat reaches the accumulator with nothing behind it
                if (r_cnt == r_acc_len && r_v2 && !r_v1)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept  = in_valid && w_in_ready;
    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_DRAIN);
    assign out_data  = out_valid ? r_acc : '0;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_iw      <= 4'd8;
            r_ww      <= 4'd8;
            r_s_in    <= 1'b0;
            r_s_w     <= 1'b0;
            r_acc_len <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_in1     <= '0;
            r_w1      <= '0;
            r_sum2    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && cfg_valid) begin
                r_iw      <= norm_w(cfg_in_width);
                r_ww      <= norm_w(cfg_weight_width);
                r_s_in    <= cfg_s_in;
                r_s_w     <= cfg_s_weight;
                r_acc_len <= cfg_acc_len;
                r_acc     <= cfg_psum_init;
                r_cnt     <= '0;
            end else begin
                if (r_v2)
                    r_acc <= r_acc + r_sum2;
                if (w_accept)
                    r_cnt <= r_cnt + 1'b1;
            end
            r_v1 <= w_accept;
            if (w_accept) begin
                r_in1 <= in_data;
                r_w1  <= weight_data;
            end
            r_v2 <= r_v1;
            if (r_v1)
                r_sum2 <= w_sum;
        end
    end

endmodule

// File: tb/tb_fusion_pe_acc.sv
// Directed bench for fusion_pe_acc: single-beat vector table plus hand-written
// accumulation, backpressure, zero-length and asynchronous-reset sequences.
module tb_fusion_pe_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [3:0]  cfg_in_width, cfg_weight_width;
    logic        cfg_s_in, cfg_s_weight;
    logic [7:0]  cfg_acc_len;
    logic [31:0] cfg_psum_init;
    logic        in_valid, in_ready;
    logic [7:0]  in_data, weight_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  iw;
        logic [3:0]  ww;
        logic        si;
        logic        sw;
        logic [7:0]  din;
        logic [7:0]  wgt;
        logic [31:0] init;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    fusion_pe_acc #(.DATA_W(8), .ACC_W(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_acc_len(cfg_acc_len),
        .cfg_psum_init(cfg_psum_init),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .weight_data(weight_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [3:0] iw, input logic [3:0] ww, input logic si,
                           input logic sw, input logic [7:0] len, input logic [31:0] init);
        cfg_in_width     = iw;
        cfg_weight_width = ww;
        cfg_s_in         = si;
        cfg_s_weight     = sw;
        cfg_acc_len      = len;
        cfg_psum_init    = init;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        set_cfg(v.iw, v.ww, v.si, v.sw, 8'd1, v.init);
        cfg_valid = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        in_valid    = 1'b1;
        in_data     = v.din;
        weight_data = v.wgt;
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check({nm, "_valid_early"}, 32'(out_valid), 32'd0);
        tick();
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_data"}, out_data, v.exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'd8, 4'd8, 1'b1, 1'b1, 8'hFE, 8'h03, 32'd0,   32'hFFFF_FFFA};
        vecs[1] = '{4'd4, 4'd4, 1'b0, 1'b0, 8'h21, 8'h43, 32'd0,   32'h0000_000B};
        vecs[2] = '{4'd2, 4'd2, 1'b1, 1'b0, 8'hFF, 8'h55, 32'd0,   32'hFFFF_FFFC};
        vecs[3] = '{4'd4, 4'd4, 1'b1, 1'b1, 8'h8F, 8'h7F, 32'd0,   32'hFFFF_FFC9};
        vecs[4] = '{4'd8, 4'd8, 1'b0, 1'b0, 8'hFF, 8'hFF, 32'd0,   32'h0000_FE01};
        vecs[5] = '{4'd8, 4'd2, 1'b0, 1'b1, 8'h05, 8'hFE, 32'd0,   32'hFFFF_FFF6};
        vecs[6] = '{4'd3, 4'd3, 1'b0, 1'b0, 8'h10, 8'h10, 32'd0,   32'h0000_0100};
        vecs[7] = '{4'd4, 4'd4, 1'b0, 1'b0, 8'h21, 8'h43, 32'd100, 32'h0000_006F};
        vecs[8] = '{4'd2, 4'd4, 1'b0, 1'b0, 8'hE7, 8'h31, 32'd0,   32'h0000_0006};

        rst         = 1'b1;
        cfg_valid   = 1'b0;
        set_cfg(4'd8, 4'd8, 1'b0, 1'b0, 8'd0, 32'd0);
        in_valid    = 1'b0;
        in_data     = '0;
        weight_data = '0;
        out_ready   = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #9 rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // three beats onto bias 10 with a two-cycle gap
        set_cfg(4'd8, 4'd8, 1'b0, 1'b0, 8'd3, 32'd10);
        cfg_valid = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'd2;
        weight_data = 8'd3;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        tick();
        tick();
        check("acc_ready_low", 32'(in_ready), 32'd0);
        in_data     = 8'd100;
        weight_data = 8'd100;
        tick();
        check("acc_valid_early", 32'(out_valid), 32'd0);
        tick();
        check("acc_valid", 32'(out_valid), 32'd1);
        check("acc_data", out_data, 32'd28);

        // hold the result under backpressure; a config strobe must be ignored
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                set_cfg(4'd8, 4'd8, 1'b0, 1'b0, 8'd0, 32'h1234);
                cfg_valid = 1'b1;
            end
            tick();
            cfg_valid = 1'b0;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", out_data, 32'd28);
            check("bp_busy", 32'(busy), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_released", 32'(out_valid), 32'd0);

        // zero-length job straight after the handshake, with a beat on offer
        set_cfg(4'd8, 4'd8, 1'b0, 1'b0, 8'd0, 32'h1234);
        cfg_valid   = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'd9;
        weight_data = 8'd9;
        tick();
        cfg_valid = 1'b0;
        check("len0_valid", 32'(out_valid), 32'd1);
        check("len0_data", out_data, 32'h1234);
        check("len0_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        tick();
        check("len0_data_hold", out_data, 32'h1234);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("len0_idle", 32'(busy), 32'd0);

        // asynchronous reset after one of three beats
        set_cfg(4'd8, 4'd8, 1'b0, 1'b0, 8'd3, 32'd7);
        cfg_valid = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'd4;
        weight_data = 8'd4;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        #2 rst = 1'b0;
        tick();
        run_vec('{4'd8, 4'd8, 1'b0, 1'b0, 8'd5, 8'd5, 32'd0, 32'd25}, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fusion_pe_acc.md
Name: fusion_pe_acc

Overview:
Parametrised successor to the single registered fusion-unit wrapper. It is a bit-fusion processing element that takes packed low-precision input and weight operands (2/4/8-bit, signed or unsigned) over valid/ready handshakes. It computes the lane-wise dot product of each beat and accumulates a programmable number of beats onto a bias. The final partial sum is presented on a handshaked output port. It sits in a systolic column between operand/psum buffers and the next PE or the output buffer.

Parameters:
DATA_W, 8, operand bus width in bits; power of two, minimum 8
ACC_W, 32, accumulator and psum width; must be at least 2*DATA_W + CNT_W
CNT_W, 8, width of the accumulation-length counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  configuration strobe; honoured in IDLE only
cfg_in_width  in  4  input precision code: 2, 4 or 8; any other value is treated as 8
cfg_weight_width  in  4  weight precision code, same encoding
cfg_s_in  in  1  1 = input lanes are signed
cfg_s_weight  in  1  1 = weight lanes are signed
cfg_acc_len  in  CNT_W  number of beats to accumulate
cfg_psum_init  in  ACC_W  bias loaded into the accumulator
in_valid  in  1  operand beat valid
in_ready  out  1  PE can accept a beat
in_data  in  DATA_W  packed input lanes
weight_data  in  DATA_W  packed weight lanes
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  ACC_W  accumulated psum
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, any time including mid-operation):
  - state = IDLE
  - in_ready = 0, out_valid = 0, out_data = 0, busy = 0
  - accumulator, beat counter and both pipeline valid bits cleared
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - in_ready = 0.
  - If cfg_valid is high, latch all cfg_* fields, set acc = cfg_psum_init, set count = 0.
  - Next state is ACCUM, or DRAIN if cfg_acc_len == 0. In the DRAIN case out_data = cfg_psum_init, with out_valid high the cycle after the strobe.
- ACCUM:
  - in_ready = (count < acc_len).
  - A beat is accepted when in_valid && in_ready; count increments on each accepted beat.
  - When count == acc_len, in_ready drops and the PE waits for the pipeline to empty.
- Pipeline, for a beat accepted at edge E0:
  - E0: operands are registered (stage 1).
  - E1: the lane dot-product sum is registered (stage 2).
  - E2: acc += sum, wrapping modulo 2^ACC_W.
  - The PE sustains one beat per cycle with no bubbles.
- Lane rules:
  - W = max(iw, ww); lanes L = DATA_W / W.
  - Lane k input operand = in_data[k*iw +: iw]; lane k weight operand = weight_data[k*ww +: ww]. Lane positions are computed with the lane's own width, so when iw != ww the unused upper bits of the narrower bus are ignored.
  - Each operand is sign-extended if its s_* flag is set, otherwise zero-extended.
  - The lane product is exact. Lane products are summed and the sum is sign-extended to ACC_W.
- DRAIN:
  - Entered at the edge where the last beat is accumulated (E2 of the last beat), so out_valid rises 3 edges after the last accept.
  - out_data = acc; out_data and out_valid are held stable while out_ready is low.
  - When out_valid && out_ready: next state IDLE, out_valid = 0 on the following cycle.
- cfg_valid outside IDLE is ignored, as are in_valid beats presented while in_ready is low.
- The configuration is frozen from the strobe until the PE returns to IDLE.
- out_ready arriving in the same cycle that DRAIN is entered takes effect at the next edge; minimum result occupancy is 1 cycle.
- A new cfg_valid is accepted in the first IDLE cycle after the result handshake (back-to-back jobs with one idle cycle).

Test Plan:
- 8x8 signed: cfg 8/8, s=1/1, acc_len=1, init=0; beat in=0xFE, w=0x03 -> out_data=0xFFFFFFFA (-6); out_valid 3 edges after accept.
- 4x4 unsigned: cfg 4/4, s=0/0, acc_len=1, init=0; in=0x21, w=0x43 -> 1*3 + 2*4 = 11 (0x0000000B).
- 2x2 mixed signed: cfg 2/2, s_in=1, s_w=0, acc_len=1; in=0xFF, w=0x55 -> 4 lanes of (-1*1) -> 0xFFFFFFFC (-4).
- Accumulate with bias and gaps: cfg 8/8 unsigned, acc_len=3, init=10.
  - Beats (2,3) x3, with in_valid dropped for 2 cycles between beats 1 and 2 -> out_data=28.
  - in_ready low after the third accept; a fourth in_valid is not consumed.
- Backpressure and acc_len=0:
  - Hold out_ready=0 for 5 cycles -> out_data/out_valid stable, cfg_valid ignored, busy=1.
  - Then cfg acc_len=0, init=0x1234 -> out_data=0x1234 the cycle after the strobe, with no beat consumed.
- Reset mid-ACCUM: assert rst asynchronously after 1 of 3 beats -> outputs 0 immediately; after release, a fresh acc_len=1 job (in=5, w=5) -> 25.
